pipe_hazard_unit: RTL and testbench
===================================

Name: pipe_hazard_unit

Overview:
Parametrised hazard, stall and forwarding controller for the five-stage pipeline (Fetch, Decode, Execute, Memory, WriteBack).
- Keeps a shadow record of the instructions in the E, M and W stages.
- Drives the enables of the PC and of the F/D, D/E, E/M and M/W buffers.
- Inserts bubbles, flushes F/D on a taken branch or jump, and generates per-operand forwarding selects for the Execute stage.
- Freezes the whole pipe for multi-cycle memory accesses.

Parameters:
RA_W, 3, register-index width (2^RA_W architectural registers, no hard-wired zero register)
MEM_LAT, 1, cycles a load/store occupies the M stage (>=1)
CNT_W, 16, width of stall performance counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-high
d_valid  in  1  Decode holds a real instruction
d_src0, d_src1  in  RA_W each  Decode source register indices
d_src0_used, d_src1_used  in  1 each  source actually read by the instruction
d_dst  in  RA_W  Decode destination index
d_regwr  in  1  Decode instruction writes the register file
d_memrd, d_memwr  in  1 each  Decode instruction is a load / store
ex_flush  in  1  taken branch or jump resolved in E
pc_en  out  1  PC update enable
fd_en  out  1  F/D buffer enable
fd_flush  out  1  F/D loads a NOP
de_bubble  out  1  D/E loads a NOP (control signals zeroed)
pipe_en  out  1  enable for the D/E, E/M and M/W buffers
fwd_a, fwd_b  out  2 each  E operand source: 00 register value, 01 E/M ALU result, 10 M/W write-back data
freeze  out  1  memory wait in progress
stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0

Behaviour:
- Shadow stages E, M and W each hold: valid, regwr, ld, mem (=ld|st), dst.
- E additionally holds src0, src1, src0_used, src1_used.
- Reset (asynchronous): all shadow valid=0, FSM=RUN, wait counter=0, stall_cnt=0.
- Outputs during and after reset: pc_en=1, fd_en=1, pipe_en=1, fd_flush=0, de_bubble=0, fwd_a=fwd_b=00, freeze=0.
- FSM states: RUN and WAIT.
- RUN->WAIT when MEM_LAT>1 and a valid mem instruction advances into M; the wait counter loads MEM_LAT-1.
- In WAIT: freeze=1; the counter decrements each cycle; WAIT->RUN on the cycle the counter reaches 0 from 1.
- MEM_LAT=1: WAIT is never entered.
- Load-use hazard (luh) = d_valid & E.valid & E.ld & ((d_src0_used & d_src0==E.dst) | (d_src1_used & d_src1==E.dst)).
- Priority, highest first: freeze > ex_flush > luh > normal.
- freeze:
  - pc_en=fd_en=pipe_en=0; all shadow stages hold.
  - fd_flush=0, de_bubble=0.
  - ex_flush is not acted on; it is held by the frozen E stage and is acted on when the freeze ends.
- ex_flush (not frozen):
  - fd_flush=1, de_bubble=1, pc_en=1, pipe_en=1.
  - Shadow: E<=invalid, M<=E, W<=M.
  - A luh in the same cycle is ignored.
- luh (not frozen, no flush):
  - pc_en=0, fd_en=0, de_bubble=1, pipe_en=1.
  - Shadow: E<=invalid, M<=E, W<=M.
  - Exactly one stall cycle per load-use pair.
- normal:
  - All enables 1, fd_flush=0, de_bubble=0.
  - Shadow: E<=Decode fields (valid=d_valid), M<=E, W<=M.
- Forwarding (combinational from shadow), per operand k with E.valid & E.srck_used:
  - 01 if M.valid & M.regwr & ~M.ld & M.dst==E.srck (M has priority over W).
  - else 10 if W.valid & W.regwr & W.dst==E.srck.
  - else 00.
  - Unused or invalid operands give 00.
- fwd_* remain valid while frozen, since the shadow holds.
- stall_cnt increments on every cycle with pc_en=0 (luh or freeze) and saturates at all-ones.
- Reset mid-WAIT or mid-stall: everything returns to the reset state at once; no pending flush or freeze survives reset.

Test Plan:
- Back-to-back ALU ops, R1<=..., then ADD R2,R1,R3 (no mem) -> second op in E has fwd_a=01, no stall, stall_cnt stays 0.
- ALU writes R4, one unrelated instruction, then reader of R4 as operand b -> fwd_b=10 when the reader is in E.
- LOAD R5, then an immediate reader of R5 (MEM_LAT=1) -> one cycle with pc_en=0, fd_en=0, de_bubble=1; next cycle reader in E with fwd=10; stall_cnt=1.
- ex_flush asserted in the same cycle as a luh -> fd_flush=1, de_bubble=1, pc_en=1, no stall, stall_cnt unchanged.
- MEM_LAT=3: STORE enters M -> freeze=1 for exactly 2 cycles with pipe_en=0, shadow and fwd outputs held, then RUN; stall_cnt +2.
- Assert rst during the second WAIT cycle -> freeze=0, all enables=1 and stall_cnt=0 immediately without a clock edge; the next STORE with MEM_LAT=3 freezes for 2 cycles again.

Source files
------------

// File: rtl/pipe_hazard_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_if : Decode/flush inputs and stall/forward controls of the hazard unit. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface pipe_hazard_if #(
  parameter int RA_W  = 3,
  parameter int CNT_W = 16
);
  logic            d_valid;
  logic [RA_W-1:0] d_src0;
  logic [RA_W-1:0] d_src1;
  logic            d_src0_used;
  logic            d_src1_used;
  logic [RA_W-1:0] d_dst;
  logic            d_regwr;
  logic            d_memrd;
  logic            d_memwr;
  logic            ex_flush;

  logic             pc_en;
  logic             fd_en;
  logic             fd_flush;
  logic             de_bubble;
  logic             pipe_en;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             freeze;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output d_valid, d_src0, d_src1, d_src0_used, d_src1_used, d_dst,
           d_regwr, d_memrd, d_memwr, ex_flush,
    input  pc_en, fd_en, fd_flush, de_bubble, pipe_en, fwd_a, fwd_b,
           freeze, stall_cnt
  );

  modport slave (
    input  d_valid, d_src0, d_src1, d_src0_used, d_src1_used, d_dst,
           d_regwr, d_memrd, d_memwr, ex_flush,
    output pc_en, fd_en, fd_flush, de_bubble, pipe_en, fwd_a, fwd_b,
           freeze, stall_cnt
  );
endinterface

`default_nettype wire

// File: rtl/pipe_hazard_unit.sv
// ---------------------------------------------------------------------------
// pipe_hazard_unit : 5-stage hazard/stall/forwarding controller with memory freeze. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipe_hazard_unit #(
  parameter int RA_W    = 3,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  wire logic    clk,
  input  wire logic    rst,
  pipe_hazard_if.slave bus
);
  localparam int                c_WC_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [c_WC_W-1:0] c_WC_LOAD = c_WC_W'(MEM_LAT - 1);
  localparam logic [c_WC_W-1:0] c_WC_ONE  = c_WC_W'(1);
  localparam logic [0:0]        c_S_RUN   = 1'b0;
  localparam logic [0:0]        c_S_WAIT  = 1'b1;

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [c_WC_W-1:0] r_wcnt;
  logic [c_WC_W-1:0] w_wcnt_nxt;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic            r_e_valid, r_e_regwr, r_e_ld, r_e_mem;
  logic            r_e_src0_used, r_e_src1_used;
  logic [RA_W-1:0] r_e_dst, r_e_src0, r_e_src1;
  logic            r_m_valid, r_m_regwr, r_m_ld;
  logic [RA_W-1:0] r_m_dst;
  logic            r_w_valid, r_w_regwr;
  logic [RA_W-1:0] r_w_dst;

  logic w_freeze, w_luh, w_kill, w_stall;

  assign w_freeze = (r_state == c_S_WAIT);
  assign w_luh    = bus.d_valid & r_e_valid & r_e_ld &
                    ((bus.d_src0_used & (bus.d_src0 == r_e_dst)) |
                     (bus.d_src1_used & (bus.d_src1 == r_e_dst)));
  assign w_kill   = bus.ex_flush | w_luh;
  // A flush outranks the load-use stall, so only an unflushed luh stops the PC.
  assign w_stall  = w_freeze | (w_luh & ~bus.ex_flush);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_S_RUN;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    case (r_state)
      c_S_RUN: begin
        if ((MEM_LAT > 1) && r_e_valid && r_e_mem) begin
          w_state_nxt = c_S_WAIT;
          w_wcnt_nxt  = c_WC_LOAD;
        end
      end
      c_S_WAIT: begin
        w_wcnt_nxt = r_wcnt - c_WC_ONE;
        if (r_wcnt == c_WC_ONE) w_state_nxt = c_S_RUN;
      end
      default: w_state_nxt = c_S_RUN;
    endcase
  end

  always_comb begin
    bus.pc_en     = 1'b1;
    bus.fd_en     = 1'b1;
    bus.fd_flush  = 1'b0;
    bus.de_bubble = 1'b0;
    bus.pipe_en   = 1'b1;
    bus.freeze    = 1'b0;
    if (w_freeze) begin
      bus.pc_en   = 1'b0;
      bus.fd_en   = 1'b0;
      bus.pipe_en = 1'b0;
      bus.freeze  = 1'b1;
    end else if (bus.ex_flush && !rst) begin
      bus.fd_flush  = 1'b1;
      bus.de_bubble = 1'b1;
    end else if (w_luh) begin
      bus.pc_en     = 1'b0;
      bus.fd_en     = 1'b0;
      bus.de_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_e_valid     <= 1'b0;
      r_e_regwr     <= 1'b0;
      r_e_ld        <= 1'b0;
      r_e_mem       <= 1'b0;
      r_e_src0_used <= 1'b0;
      r_e_src1_used <= 1'b0;
      r_e_dst       <= '0;
      r_e_src0      <= '0;
      r_e_src1      <= '0;
      r_m_valid     <= 1'b0;
      r_m_regwr     <= 1'b0;
      r_m_ld        <= 1'b0;
      r_m_dst       <= '0;
      r_w_valid     <= 1'b0;
      r_w_regwr     <= 1'b0;
      r_w_dst       <= '0;
    end else if (!w_freeze) begin
      r_e_valid     <= bus.d_valid & ~w_kill;
      r_e_regwr     <= bus.d_regwr;
      r_e_ld        <= bus.d_memrd;
      r_e_mem       <= bus.d_memrd | bus.d_memwr;
      r_e_src0_used <= bus.d_src0_used;
      r_e_src1_used <= bus.d_src1_used;
      r_e_dst       <= bus.d_dst;
      r_e_src0      <= bus.d_src0;
      r_e_src1      <= bus.d_src1;
      r_m_valid     <= r_e_valid;
      r_m_regwr     <= r_e_regwr;
      r_m_ld        <= r_e_ld;
      r_m_dst       <= r_e_dst;
      r_w_valid     <= r_m_valid;
      r_w_regwr     <= r_m_regwr;
      r_w_dst       <= r_m_dst;
    end
  end

  // A load's data is not ready in E/M, so it can only be forwarded from M/W.
  function automatic logic [1:0] fwd_sel(input logic used, input logic [RA_W-1:0] src);
    logic [1:0] sel;
    sel = 2'b00;
    if (r_e_valid && used) begin
      if (r_m_valid && r_m_regwr && !r_m_ld && (r_m_dst == src)) sel = 2'b01;
      else if (r_w_valid && r_w_regwr && (r_w_dst == src))      sel = 2'b10;
    end
    return sel;
  endfunction

  assign bus.fwd_a = fwd_sel(r_e_src0_used, r_e_src0);
  assign bus.fwd_b = fwd_sel(r_e_src1_used, r_e_src1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  r_stall_cnt <= '0;
    else if (w_stall && (r_stall_cnt != '1))  r_stall_cnt <= r_stall_cnt + CNT_W'(1);
  end

  assign bus.stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_unit : directed checks on a MEM_LAT=1 and a MEM_LAT=3 (2-bit counter) unit. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pipe_hazard_unit;
  localparam logic [31:0] NRM = 32'h32;  // pc fd - - pipe -
  localparam logic [31:0] LUH = 32'h06;
  localparam logic [31:0] FLS = 32'h3E;
  localparam logic [31:0] FRZ = 32'h01;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  logic       d_valid, u0, u1, wr, ld, st, flush;
  logic [2:0] s0, s1, dst;

  pipe_hazard_if #(.RA_W(3), .CNT_W(16)) if1 ();
  pipe_hazard_if #(.RA_W(3), .CNT_W(2))  if3 ();

  pipe_hazard_unit #(.RA_W(3), .MEM_LAT(1), .CNT_W(16)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  pipe_hazard_unit #(.RA_W(3), .MEM_LAT(3), .CNT_W(2))  u_dut3 (.clk(clk), .rst(rst), .bus(if3));

  assign if1.d_valid = d_valid;  assign if3.d_valid = d_valid;
  assign if1.d_src0 = s0;        assign if3.d_src0 = s0;
  assign if1.d_src1 = s1;        assign if3.d_src1 = s1;
  assign if1.d_src0_used = u0;   assign if3.d_src0_used = u0;
  assign if1.d_src1_used = u1;   assign if3.d_src1_used = u1;
  assign if1.d_dst = dst;        assign if3.d_dst = dst;
  assign if1.d_regwr = wr;       assign if3.d_regwr = wr;
  assign if1.d_memrd = ld;       assign if3.d_memrd = ld;
  assign if1.d_memwr = st;       assign if3.d_memwr = st;
  assign if1.ex_flush = flush;   assign if3.ex_flush = flush;

  logic [31:0] ctl1, ctl3, fa1, fb1, fa3, cnt1, cnt3;
  assign ctl1 = {26'd0, if1.pc_en, if1.fd_en, if1.fd_flush, if1.de_bubble, if1.pipe_en, if1.freeze};
  assign ctl3 = {26'd0, if3.pc_en, if3.fd_en, if3.fd_flush, if3.de_bubble, if3.pipe_en, if3.freeze};
  assign fa1  = {30'd0, if1.fwd_a};
  assign fb1  = {30'd0, if1.fwd_b};
  assign fa3  = {30'd0, if3.fwd_a};
  assign cnt1 = {16'd0, if1.stall_cnt};
  assign cnt3 = {30'd0, if3.stall_cnt};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic di(input logic v, input logic [2:0] a, input logic ua, input logic [2:0] b,
                    input logic ub, input logic [2:0] d, input logic w, input logic l, input logic s);
    d_valid = v; s0 = a; u0 = ua; s1 = b; u1 = ub; dst = d; wr = w; ld = l; st = s;
  endtask

  task automatic nop();
    di(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    flush = 1'b1;
    di(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0);
    #3;
    chk("rst_ctl1", ctl1, NRM);
    chk("rst_ctl3", ctl3, NRM);
    chk("rst_fwd_a", fa1, 32'd0);
    chk("rst_fwd_b", fb1, 32'd0);
    chk("rst_cnt", cnt1, 32'd0);
    flush = 1'b0;
    nop();
    #1 rst = 1'b0;

    // ALU R1 then ADD R2,R1,R3: E/M forward on operand a
    step(); di(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0);
    #2 chk("alu1_ctl", ctl1, NRM);
    step(); di(1'b1, 3'd1, 1'b1, 3'd3, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
    #2 chk("add_ctl", ctl1, NRM);
    step(); nop();
    #2 chk("b2b_fwd_a", fa1, 32'd1);
    chk("b2b_fwd_b", fb1, 32'd0);
    chk("b2b_cnt", cnt1, 32'd0);

    // R4 writer, unrelated, reader of R4 on operand b: M/W forward
    step(); di(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0);
    step(); di(1'b1, 3'd7, 1'b0, 3'd7, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0);
    step(); di(1'b1, 3'd2, 1'b1, 3'd4, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
    step(); nop();
    #2 chk("gap_fwd_b", fb1, 32'd2);
    chk("gap_fwd_a", fa1, 32'd0);

    // LOAD R5 then immediate reader: one stall, then M/W forward
    step(); di(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0);
    #2 chk("ld_ctl", ctl1, NRM);
    step(); di(1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0);
    #2 chk("luh_ctl", ctl1, LUH);
    chk("luh_cnt0", cnt1, 32'd0);
    step();
    #2 chk("post_luh_ctl", ctl1, NRM);
    chk("luh_cnt1", cnt1, 32'd1);
    step(); nop();
    #2 chk("luh_fwd_a", fa1, 32'd2);
    chk("luh_cnt_hold", cnt1, 32'd1);

    // flush in the same cycle as a load-use hazard
    step(); di(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0);
    step(); di(1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    #2 chk("flush_luh_ctl", ctl1, FLS);
    step(); flush = 1'b0; nop();
    #2 chk("flush_after_ctl", ctl1, NRM);
    chk("flush_cnt", cnt1, 32'd1);

    // two writers of R6: M wins over W; unused operand a never forwards
    step(); di(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0);
    step(); di(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0);
    step(); di(1'b1, 3'd6, 1'b0, 3'd6, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    step(); nop();
    #2 chk("prio_fwd_b", fb1, 32'd1);
    chk("unused_fwd_a", fa1, 32'd0);

    // MEM_LAT=3 unit from a clean reset
    step(); rst = 1'b1;
    #1 chk("ph2_rst_cnt", cnt3, 32'd0);
    rst = 1'b0;

    step(); di(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0);
    step(); di(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    step(); di(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0);
    #2 chk("st_in_e_ctl", ctl3, NRM);
    step(); nop();
    #2 chk("frz1_ctl", ctl3, FRZ);
    chk("frz1_fwd_a", fa3, 32'd2);
    chk("frz1_cnt", cnt3, 32'd0);
    step(); flush = 1'b1;
    #2 chk("frz2_ctl_flush_held", ctl3, FRZ);
    chk("frz2_fwd_a", fa3, 32'd2);
    chk("frz2_cnt", cnt3, 32'd1);
    step();
    #2 chk("unfrz_flush_ctl", ctl3, FLS);
    chk("unfrz_fwd_a", fa3, 32'd2);
    chk("unfrz_cnt", cnt3, 32'd2);

    // reset during the second WAIT cycle
    step(); flush = 1'b0; di(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    step(); nop();
    step();
    #2 chk("w1_ctl", ctl3, FRZ);
    step(); rst = 1'b1;
    #1 chk("rst_wait_ctl", ctl3, NRM);
    chk("rst_wait_cnt", cnt3, 32'd0);
    rst = 1'b0;
    di(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    step(); nop();
    #2 chk("st2_e_ctl", ctl3, NRM);
    step();
    #2 chk("st2_frz1", ctl3, FRZ);
    chk("lat1_no_wait", ctl1, NRM);
    step();
    #2 chk("st2_frz2", ctl3, FRZ);
    chk("st2_frz2_cnt", cnt3, 32'd1);
    step();
    #2 chk("st2_run", ctl3, NRM);
    chk("st2_cnt", cnt3, 32'd2);

    // third freeze drives the 2-bit counter into saturation
    di(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    step(); nop();
    step();
    #2 chk("st3_frz1", ctl3, FRZ);
    step();
    #2 chk("sat_cnt3", cnt3, 32'd3);
    step();
    #2 chk("st3_run", ctl3, NRM);
    chk("sat_hold", cnt3, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
